// File: rtl/wg_alloc_requester_pkg.sv
// Shared definitions for the workgroup allocation requester.
// Widths/limits are macros so the resource table and the requester can share
// one set of values; FSM state encoding and slot count live in the package.
// Macros (overridable): WF_COUNT_WIDTH, WF_COUNT_WIDTH_PER_WG, WG_SLOT_ID_WIDTH,
// WF_COUNT_MAX.
`ifndef WF_COUNT_WIDTH
`define WF_COUNT_WIDTH 4
`endif
`ifndef WF_COUNT_WIDTH_PER_WG
`define WF_COUNT_WIDTH_PER_WG 4
`endif
`ifndef WG_SLOT_ID_WIDTH
`define WG_SLOT_ID_WIDTH 2
`endif
`ifndef WF_COUNT_MAX
`define WF_COUNT_MAX 8
`endif

package wg_alloc_requester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ALLOC = 3'd2,
        ST_RESP  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam int WG_SLOTS = 1 << `WG_SLOT_ID_WIDTH;

endpackage

// File: rtl/wg_alloc_requester_pick.sv
// wg_slot_pick_first: combinational lowest-index idle slot finder for one
// CU's busy bitmap row.
// Ports:
//   i_busy  : busy bitmap, bit n = slot n occupied
//   o_slot  : lowest idle slot index (0 when none)
//   o_found : at least one idle slot exists
module wg_slot_pick_first #(
    parameter int SLOT_W = 2
) (
    input  logic [(1<<SLOT_W)-1:0] i_busy,
    output logic [SLOT_W-1:0]      o_slot,
    output logic                   o_found
);
    always_comb begin
        o_found = 1'b0;
        o_slot  = '0;
        // Walk high to low so the last hit written is the lowest index.
        for (int i = (1 << SLOT_W) - 1; i >= 0; i--) begin
            if (!i_busy[i]) begin
                o_found = 1'b1;
                o_slot  = SLOT_W'(i);
            end
        end
    end
endmodule

// File: rtl/wg_alloc_requester.sv
// wg_alloc_requester: initiator side of the per-CU workgroup resource table.
// Accepts WG dispatch requests, scans CUs through the table's single cu_id
// port (1-cycle read latency) for enough free wavefronts plus an idle WG slot,
// then issues an alloc strobe and returns the chosen CU/slot. WG completions
// are forwarded as dealloc strobes; deallocs of idle slots raise a sticky error.
// Ports:
//   wg_*      : dispatch request (valid/ready, wavefront count)
//   alloc_*   : allocation result (valid/ready, cu, slot)
//   dealloc_* : completion (valid/ready, cu, slot)
//   tbl_*     : resource table command/read port
//   dealloc_err_o : sticky dealloc-of-idle-slot flag
// Optional: WG_ALLOC_RR_EN makes the scan start after the last allocated CU
// (round-robin); otherwise scanning always starts at CU 0.
`ifndef WF_COUNT_WIDTH
`define WF_COUNT_WIDTH 4
`endif
`ifndef WF_COUNT_WIDTH_PER_WG
`define WF_COUNT_WIDTH_PER_WG 4
`endif
`ifndef WG_SLOT_ID_WIDTH
`define WG_SLOT_ID_WIDTH 2
`endif
`ifndef WF_COUNT_MAX
`define WF_COUNT_MAX 8
`endif

module wg_alloc_requester
    import wg_alloc_requester_pkg::*;
#(
    parameter int NUMBER_CU   = 2,
    parameter int CU_ID_WIDTH = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wg_valid_i,
    output logic                              wg_ready_o,
    input  logic [`WF_COUNT_WIDTH_PER_WG-1:0] wg_wf_count_i,
    output logic                              alloc_valid_o,
    input  logic                              alloc_ready_i,
    output logic [CU_ID_WIDTH-1:0]            alloc_cu_id_o,
    output logic [`WG_SLOT_ID_WIDTH-1:0]      alloc_slot_id_o,
    input  logic                              dealloc_valid_i,
    output logic                              dealloc_ready_o,
    input  logic [CU_ID_WIDTH-1:0]            dealloc_cu_id_i,
    input  logic [`WG_SLOT_ID_WIDTH-1:0]      dealloc_slot_id_i,
    output logic [CU_ID_WIDTH-1:0]            tbl_cu_id_o,
    output logic                              tbl_alloc_en_o,
    output logic                              tbl_dealloc_en_o,
    output logic [`WF_COUNT_WIDTH_PER_WG-1:0] tbl_wf_count_o,
    output logic [`WG_SLOT_ID_WIDTH-1:0]      tbl_alloc_wg_slot_id_o,
    output logic [`WG_SLOT_ID_WIDTH-1:0]      tbl_dealloc_wg_slot_id_o,
    input  logic [`WF_COUNT_WIDTH-1:0]        tbl_wf_count_i,
    output logic                              dealloc_err_o
);
    localparam int SW     = `WG_SLOT_ID_WIDTH;
    localparam int STEP_W = $clog2(NUMBER_CU + 1);

    typedef logic [CU_ID_WIDTH-1:0] cu_t;
    typedef logic [SW-1:0]          slot_t;

    state_e                              r_state, w_state_nxt;
    logic [NUMBER_CU-1:0][WG_SLOTS-1:0]  r_busy;
    logic [`WF_COUNT_WIDTH_PER_WG-1:0]   r_cnt;
    cu_t                                 r_scan_ptr;
    cu_t                                 r_prev_cu;   // CU whose table read arrives this cycle
    logic [STEP_W-1:0]                   r_step;      // 0: nothing presented yet
    cu_t                                 r_alloc_cu;
    slot_t                               r_alloc_slot;
    logic                                r_err;
    cu_t                                 w_start_cu;

    function automatic cu_t f_inc(input cu_t a);
        if (32'(a) >= NUMBER_CU - 1) return '0;
        return cu_t'(a + 1'b1);
    endfunction

`ifdef WG_ALLOC_RR_EN
    cu_t r_start;
    assign w_start_cu = r_start;
`else
    assign w_start_cu = '0;
`endif

    // Idle-slot finder per CU row.
    logic [NUMBER_CU-1:0]         w_row_found;
    logic [NUMBER_CU-1:0][SW-1:0] w_row_slot;

    for (genvar g = 0; g < NUMBER_CU; g++) begin : g_pick
        wg_slot_pick_first #(.SLOT_W(SW)) u_pick (
            .i_busy  (r_busy[g]),
            .o_slot  (w_row_slot[g]),
            .o_found (w_row_found[g])
        );
    end

    logic  w_eval_fit;
    slot_t w_eval_slot;
    logic  w_dl_busy;

    assign w_eval_slot = w_row_slot[r_prev_cu];
    assign w_eval_fit  = (r_step != '0) && w_row_found[r_prev_cu] &&
                         (32'(tbl_wf_count_i) >= 32'(r_cnt));
    assign w_dl_busy   = r_busy[dealloc_cu_id_i][dealloc_slot_id_i];

    always_comb begin
        w_state_nxt              = r_state;
        wg_ready_o               = 1'b0;
        alloc_valid_o            = 1'b0;
        alloc_cu_id_o            = '0;
        alloc_slot_id_o          = '0;
        dealloc_ready_o          = 1'b0;
        tbl_cu_id_o              = '0;
        tbl_alloc_en_o           = 1'b0;
        tbl_dealloc_en_o         = 1'b0;
        tbl_wf_count_o           = '0;
        tbl_alloc_wg_slot_id_o   = '0;
        tbl_dealloc_wg_slot_id_o = '0;
        case (r_state)
            ST_IDLE, ST_WAIT: begin
                if (dealloc_valid_i) begin
                    dealloc_ready_o = 1'b1;
                    if (w_dl_busy) begin
                        tbl_cu_id_o              = dealloc_cu_id_i;
                        tbl_dealloc_en_o         = 1'b1;
                        tbl_dealloc_wg_slot_id_o = dealloc_slot_id_i;
                        // A freed slot may let the parked WG fit now.
                        if (r_state == ST_WAIT) w_state_nxt = ST_SCAN;
                    end
                end else if (wg_valid_i && r_state == ST_IDLE) begin
                    wg_ready_o  = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                tbl_cu_id_o = r_scan_ptr;
                if (w_eval_fit)                              w_state_nxt = ST_ALLOC;
                else if (r_step == STEP_W'(NUMBER_CU))       w_state_nxt = ST_WAIT;
            end
            ST_ALLOC: begin
                tbl_cu_id_o            = r_alloc_cu;
                tbl_alloc_en_o         = 1'b1;
                tbl_wf_count_o         = r_cnt;
                tbl_alloc_wg_slot_id_o = r_alloc_slot;
                w_state_nxt            = ST_RESP;
            end
            ST_RESP: begin
                alloc_valid_o   = 1'b1;
                alloc_cu_id_o   = r_alloc_cu;
                alloc_slot_id_o = r_alloc_slot;
                if (alloc_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= '0;
            r_cnt        <= '0;
            r_scan_ptr   <= '0;
            r_prev_cu    <= '0;
            r_step       <= '0;
            r_alloc_cu   <= '0;
            r_alloc_slot <= '0;
            r_err        <= 1'b0;
`ifdef WG_ALLOC_RR_EN
            r_start      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (dealloc_ready_o) begin
                if (w_dl_busy) r_busy[dealloc_cu_id_i][dealloc_slot_id_i] <= 1'b0;
                else           r_err <= 1'b1;
            end
            if (wg_ready_o) r_cnt <= wg_wf_count_i;
            if (w_state_nxt == ST_SCAN && r_state != ST_SCAN) begin
                r_scan_ptr <= w_start_cu;
                r_step     <= '0;
            end else if (r_state == ST_SCAN) begin
                r_scan_ptr <= f_inc(r_scan_ptr);
                r_prev_cu  <= r_scan_ptr;
                r_step     <= r_step + 1'b1;
                if (w_eval_fit) begin
                    r_alloc_cu   <= r_prev_cu;
                    r_alloc_slot <= w_eval_slot;
                end
            end
            if (r_state == ST_ALLOC) begin
                r_busy[r_alloc_cu][r_alloc_slot] <= 1'b1;
`ifdef WG_ALLOC_RR_EN
                r_start <= f_inc(r_alloc_cu);
`endif
            end
        end
    end

    assign dealloc_err_o = r_err;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(tbl_alloc_en_o && tbl_dealloc_en_o));
    a_wf_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (wg_valid_i && wg_ready_o) |-> (wg_wf_count_i != '0));

endmodule

// File: tb/tb_wg_alloc_requester.sv
// Bench for wg_alloc_requester: resource table model plus a placement
// reference model (first CU from the start CU with enough free wavefronts and
// an idle slot, lowest idle slot), directed scenarios and a randomized mix.
`ifndef WF_COUNT_WIDTH
`define WF_COUNT_WIDTH 4
`endif
`ifndef WF_COUNT_WIDTH_PER_WG
`define WF_COUNT_WIDTH_PER_WG 4
`endif
`ifndef WG_SLOT_ID_WIDTH
`define WG_SLOT_ID_WIDTH 2
`endif
`ifndef WF_COUNT_MAX
`define WF_COUNT_MAX 8
`endif

module tb_wg_alloc_requester;
    localparam int NCU = 2;
    localparam int NSL = 4;
`ifdef WG_ALLOC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 0, rst_n = 0;
    logic wg_valid_i = 0, wg_ready_o;
    logic [`WF_COUNT_WIDTH_PER_WG-1:0] wg_wf_count_i = '0;
    logic alloc_valid_o, alloc_ready_i = 0;
    logic [0:0] alloc_cu_id_o;
    logic [`WG_SLOT_ID_WIDTH-1:0] alloc_slot_id_o;
    logic dealloc_valid_i = 0, dealloc_ready_o;
    logic [0:0] dealloc_cu_id_i = '0;
    logic [`WG_SLOT_ID_WIDTH-1:0] dealloc_slot_id_i = '0;
    logic [0:0] tbl_cu_id_o;
    logic tbl_alloc_en_o, tbl_dealloc_en_o;
    logic [`WF_COUNT_WIDTH_PER_WG-1:0] tbl_wf_count_o;
    logic [`WG_SLOT_ID_WIDTH-1:0] tbl_alloc_wg_slot_id_o, tbl_dealloc_wg_slot_id_o;
    logic [`WF_COUNT_WIDTH-1:0] tbl_wf_count_i;
    logic dealloc_err_o;

    int total = 0, bad = 0;

    wg_alloc_requester #(.NUMBER_CU(2), .CU_ID_WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wg_valid_i(wg_valid_i), .wg_ready_o(wg_ready_o), .wg_wf_count_i(wg_wf_count_i),
        .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i),
        .alloc_cu_id_o(alloc_cu_id_o), .alloc_slot_id_o(alloc_slot_id_o),
        .dealloc_valid_i(dealloc_valid_i), .dealloc_ready_o(dealloc_ready_o),
        .dealloc_cu_id_i(dealloc_cu_id_i), .dealloc_slot_id_i(dealloc_slot_id_i),
        .tbl_cu_id_o(tbl_cu_id_o), .tbl_alloc_en_o(tbl_alloc_en_o),
        .tbl_dealloc_en_o(tbl_dealloc_en_o), .tbl_wf_count_o(tbl_wf_count_o),
        .tbl_alloc_wg_slot_id_o(tbl_alloc_wg_slot_id_o),
        .tbl_dealloc_wg_slot_id_o(tbl_dealloc_wg_slot_id_o),
        .tbl_wf_count_i(tbl_wf_count_i), .dealloc_err_o(dealloc_err_o)
    );

    always #5 clk = ~clk;

    // Resource table model: 1-cycle read latency, remembers per-slot amounts.
    int t_free [NCU];
    int t_amt  [NCU][NSL];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCU; c++) t_free[c] = `WF_COUNT_MAX;
            tbl_wf_count_i <= '0;
        end else begin
            tbl_wf_count_i <= `WF_COUNT_WIDTH'(t_free[tbl_cu_id_o]);
            if (tbl_alloc_en_o) begin
                t_free[tbl_cu_id_o] = t_free[tbl_cu_id_o] - int'(tbl_wf_count_o);
                t_amt[tbl_cu_id_o][tbl_alloc_wg_slot_id_o] = int'(tbl_wf_count_o);
            end
            if (tbl_dealloc_en_o)
                t_free[tbl_cu_id_o] = t_free[tbl_cu_id_o] + t_amt[tbl_cu_id_o][tbl_dealloc_wg_slot_id_o];
        end
    end

    // Monitor of alloc strobes.
    int cyc = 0, mon_a_n = 0, mon_a_cu = 0, mon_a_slot = 0, mon_a_cnt = 0, mon_a_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tbl_alloc_en_o) begin
            mon_a_n    <= mon_a_n + 1;
            mon_a_cu   <= int'(tbl_cu_id_o);
            mon_a_slot <= int'(tbl_alloc_wg_slot_id_o);
            mon_a_cnt  <= int'(tbl_wf_count_o);
            mon_a_cyc  <= cyc;
        end
    end

    // Placement reference model.
    int m_free [NCU];
    bit m_busy [NCU][NSL];
    int m_amt  [NCU][NSL];
    int m_start, m_nalloc;
    bit m_err;

    task automatic model_reset();
        for (int c = 0; c < NCU; c++) begin
            m_free[c] = `WF_COUNT_MAX;
            for (int s = 0; s < NSL; s++) begin m_busy[c][s] = 0; m_amt[c][s] = 0; end
        end
        m_start = 0; m_err = 0; m_nalloc = mon_a_n;
    endtask

    task automatic model_pick(input int cnt, output int cu, output int slot, output bit found);
        found = 0; cu = 0; slot = 0;
        for (int i = 0; i < NCU && !found; i++) begin
            int c;
            c = (m_start + i) % NCU;
            if (m_free[c] >= cnt)
                for (int s = 0; s < NSL && !found; s++)
                    if (!m_busy[c][s]) begin found = 1; cu = c; slot = s; end
        end
    endtask

    task automatic model_commit(input int cu, input int slot, input int cnt);
        m_free[cu] -= cnt; m_busy[cu][slot] = 1; m_amt[cu][slot] = cnt; m_nalloc++;
        if (RR) m_start = (cu + 1) % NCU;
    endtask

    task automatic do_reset();
        rst_n = 0; wg_valid_i = 0; alloc_ready_i = 0; dealloc_valid_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic issue_wg(input int cnt, output int acc);
        bit ok;
        ok = 0; acc = 0;
        @(posedge clk); #1;
        wg_valid_i = 1; wg_wf_count_i = `WF_COUNT_WIDTH_PER_WG'(cnt);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (wg_ready_o) begin ok = 1; acc = cyc; end
        end
        @(posedge clk); #1;
        wg_valid_i = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL wg_accept: wg_ready never rose (cnt %0d)", cnt); end
    endtask

    task automatic wait_alloc(input int ecu, input int eslot, input int ecnt, input string nm);
        bit seen;
        int hold;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (alloc_valid_o) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL %s_valid: alloc_valid never rose", nm); return; end
        total++;
        if (int'(alloc_cu_id_o) !== ecu || int'(alloc_slot_id_o) !== eslot) begin
            bad++; $display("FAIL %s_result: got cu%0d/slot%0d want cu%0d/slot%0d",
                            nm, alloc_cu_id_o, alloc_slot_id_o, ecu, eslot);
        end
        total++;
        if (mon_a_cu !== ecu || mon_a_slot !== eslot || mon_a_cnt !== ecnt || mon_a_n !== m_nalloc + 1) begin
            bad++; $display("FAIL %s_strobe: got cu%0d/slot%0d/cnt%0d n%0d want cu%0d/slot%0d/cnt%0d n%0d",
                            nm, mon_a_cu, mon_a_slot, mon_a_cnt, mon_a_n, ecu, eslot, ecnt, m_nalloc + 1);
        end
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (alloc_valid_o !== 1'b1 || int'(alloc_cu_id_o) !== ecu || int'(alloc_slot_id_o) !== eslot) begin
                bad++; $display("FAIL %s_hold: got v%0d cu%0d slot%0d want v1 cu%0d slot%0d",
                                nm, alloc_valid_o, alloc_cu_id_o, alloc_slot_id_o, ecu, eslot);
            end
        end
        alloc_ready_i = 1;
        @(posedge clk); #1;
        alloc_ready_i = 0;
    endtask

    task automatic run_wg(input int cnt, input string nm, output int acc);
        int cu, slot;
        bit found;
        model_pick(cnt, cu, slot, found);
        issue_wg(cnt, acc);
        wait_alloc(cu, slot, cnt, nm);
        model_commit(cu, slot, cnt);
    endtask

    task automatic do_dealloc(input int cu, input int slot, input string nm);
        bit ok, exp;
        ok = 0; exp = m_busy[cu][slot];
        @(posedge clk); #1;
        dealloc_valid_i = 1; dealloc_cu_id_i = 1'(cu); dealloc_slot_id_i = `WG_SLOT_ID_WIDTH'(slot);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (dealloc_ready_o) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s_ready: dealloc_ready never rose", nm);
        end else begin
            total++;
            if (tbl_dealloc_en_o !== exp ||
                (exp && (int'(tbl_cu_id_o) !== cu || int'(tbl_dealloc_wg_slot_id_o) !== slot))) begin
                bad++; $display("FAIL %s_strobe: got en%0d cu%0d slot%0d want en%0d cu%0d slot%0d",
                                nm, tbl_dealloc_en_o, tbl_cu_id_o, tbl_dealloc_wg_slot_id_o, exp, cu, slot);
            end
        end
        @(posedge clk); #1;
        dealloc_valid_i = 0;
        if (exp) begin m_busy[cu][slot] = 0; m_free[cu] += m_amt[cu][slot]; end
        else m_err = 1;
        @(negedge clk);
        total++;
        if (dealloc_err_o !== m_err) begin
            bad++; $display("FAIL %s_err: got %0d want %0d", nm, dealloc_err_o, m_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        total++;
        if ({wg_ready_o, alloc_valid_o, dealloc_ready_o, tbl_alloc_en_o, tbl_dealloc_en_o, dealloc_err_o} !== 6'b0 ||
            tbl_cu_id_o !== 1'b0 || alloc_cu_id_o !== 1'b0 || alloc_slot_id_o !== '0 || tbl_wf_count_o !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero in reset");
        end
        do_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({wg_ready_o, alloc_valid_o, dealloc_ready_o, tbl_alloc_en_o, tbl_dealloc_en_o, dealloc_err_o} !== 6'b0) begin
            bad++; $display("FAIL idle_outputs: got %b want 000000",
                {wg_ready_o, alloc_valid_o, dealloc_ready_o, tbl_alloc_en_o, tbl_dealloc_en_o, dealloc_err_o});
        end
    endtask

    task automatic test_basic();
        int acc;
        do_reset();
        run_wg(3, "basic", acc);
        @(negedge clk);
        total++;
        if (t_free[0] !== 5) begin bad++; $display("FAIL basic_free: got %0d want 5", t_free[0]); end
    endtask

    task automatic test_spill();
        int acc;
        do_reset();
        run_wg(6, "spill_a", acc);
        run_wg(4, "spill_b", acc);
        total++;
        if (mon_a_cu !== 1 || mon_a_slot !== 0) begin
            bad++; $display("FAIL spill_cu1: got cu%0d/slot%0d want cu1/slot0", mon_a_cu, mon_a_slot);
        end
        total++;
        if (mon_a_cyc - acc - 1 > 3) begin
            bad++; $display("FAIL spill_scan_time: got %0d want <=3", mon_a_cyc - acc - 1);
        end
    endtask

    task automatic test_wait_rescan();
        int acc, cu, slot;
        bit found, wr_seen;
        do_reset();
        run_wg(8, "wait_a", acc);
        run_wg(8, "wait_b", acc);
        issue_wg(2, acc);
        wr_seen = 0;
        @(posedge clk); #1;
        wg_valid_i = 1; wg_wf_count_i = 3;
        repeat (8) begin
            @(negedge clk);
            if (wg_ready_o || alloc_valid_o || tbl_alloc_en_o) wr_seen = 1;
        end
        @(posedge clk); #1;
        wg_valid_i = 0;
        total++;
        if (wr_seen) begin bad++; $display("FAIL wait_parked: got ready/alloc activity 1 want 0"); end
        do_dealloc(1, 0, "wait_dl");
        model_pick(2, cu, slot, found);
        wait_alloc(cu, slot, 2, "wait_rescan");
        model_commit(cu, slot, 2);
        total++;
        if (cu !== 1 || slot !== 0) begin bad++; $display("FAIL wait_model: got cu%0d/slot%0d want cu1/slot0", cu, slot); end
    endtask

    task automatic test_slot_exhaust();
        int acc;
        do_reset();
        for (int i = 0; i < 5; i++) run_wg(1, $sformatf("exh%0d", i), acc);
        if (!RR) begin
            total++;
            if (mon_a_cu !== 1 || mon_a_slot !== 0) begin
                bad++; $display("FAIL exhaust_fifth: got cu%0d/slot%0d want cu1/slot0", mon_a_cu, mon_a_slot);
            end
        end
    endtask

    task automatic test_bad_dealloc();
        int cu, slot;
        bit found;
        do_reset();
        @(posedge clk); #1;
        dealloc_valid_i = 1; dealloc_cu_id_i = 0; dealloc_slot_id_i = 3;
        wg_valid_i = 1; wg_wf_count_i = 2;
        @(negedge clk);
        total++;
        if (dealloc_ready_o !== 1'b1 || wg_ready_o !== 1'b0 || tbl_dealloc_en_o !== 1'b0) begin
            bad++; $display("FAIL bad_dl_prio: got dr%0d wr%0d den%0d want dr1 wr0 den0",
                            dealloc_ready_o, wg_ready_o, tbl_dealloc_en_o);
        end
        @(posedge clk); #1;
        dealloc_valid_i = 0;
        m_err = 1;
        @(negedge clk);
        total++;
        if (dealloc_err_o !== 1'b1 || wg_ready_o !== 1'b1) begin
            bad++; $display("FAIL bad_dl_err: got err%0d wr%0d want err1 wr1", dealloc_err_o, wg_ready_o);
        end
        @(posedge clk); #1;
        wg_valid_i = 0;
        model_pick(2, cu, slot, found);
        wait_alloc(cu, slot, 2, "bad_dl_wg");
        model_commit(cu, slot, 2);
        repeat (3) @(negedge clk);
        total++;
        if (dealloc_err_o !== 1'b1) begin bad++; $display("FAIL bad_dl_sticky: got %0d want 1", dealloc_err_o); end
    endtask

    task automatic test_rr();
        int acc;
        do_reset();
        run_wg(1, "rr_a", acc);
        run_wg(1, "rr_b", acc);
        total++;
        if (mon_a_cu !== (RR ? 1 : 0)) begin
            bad++; $display("FAIL rr_second: got cu%0d want cu%0d", mon_a_cu, RR ? 1 : 0);
        end
    endtask

    task automatic pick_busy(output int cu, output int slot);
        int n;
        n = 0; cu = 0; slot = 0;
        for (int c = 0; c < NCU; c++) for (int s = 0; s < NSL; s++) if (m_busy[c][s]) n++;
        n = $urandom_range(0, n - 1);
        for (int c = 0; c < NCU; c++) for (int s = 0; s < NSL; s++)
            if (m_busy[c][s]) begin
                if (n == 0) begin cu = c; slot = s; end
                n--;
            end
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int c = 0; c < NCU; c++) for (int s = 0; s < NSL; s++) if (m_busy[c][s]) n++;
        return n;
    endfunction

    task automatic test_random();
        int cu, slot, cnt, acc;
        bit found;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (busy_count() > 0 && $urandom_range(0, 2) == 0) begin
                pick_busy(cu, slot);
                if ($urandom_range(0, 9) == 0) begin
                    cu = $urandom_range(0, 1); slot = $urandom_range(0, 3);
                end
                do_dealloc(cu, slot, "rnd_dl");
            end else begin
                cnt = $urandom_range(1, 4);
                model_pick(cnt, cu, slot, found);
                issue_wg(cnt, acc);
                for (int k = 0; k < 8 && !found; k++) begin
                    int dc, ds;
                    pick_busy(dc, ds);
                    do_dealloc(dc, ds, "rnd_wait_dl");
                    model_pick(cnt, cu, slot, found);
                end
                wait_alloc(cu, slot, cnt, "rnd_wg");
                model_commit(cu, slot, cnt);
            end
        end
        @(negedge clk);
        for (int c = 0; c < NCU; c++) begin
            total++;
            if (t_free[c] !== m_free[c]) begin
                bad++; $display("FAIL rnd_free_cu%0d: got %0d want %0d", c, t_free[c], m_free[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spill();
        test_wait_rescan();
        test_slot_exhaust();
        test_bad_dealloc();
        test_rr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wg_alloc_requester.md
Name: wg_alloc_requester

Overview:
- Initiator side of the per-CU workgroup resource table.
- Accepts workgroup dispatch requests and time-multiplexes the table's single cu_id port. It scans CUs for free wavefront capacity and a free WG slot, then issues alloc pulses.
- Also forwards workgroup-completion deallocations to the table.
- Sits between the CTA dispatcher front end and the resource table in cta_top.

Parameters:
- NUMBER_CU, 2, number of compute units tracked.
- CU_ID_WIDTH, 1, width of CU index; 2^CU_ID_WIDTH >= NUMBER_CU.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wg_valid_i  in  1  dispatch request valid
- wg_ready_o  out  1  dispatch request accepted this cycle
- wg_wf_count_i  in  `WF_COUNT_WIDTH_PER_WG  wavefronts needed by the WG
- alloc_valid_o  out  1  allocation result valid
- alloc_ready_i  in  1  consumer accepts result
- alloc_cu_id_o  out  CU_ID_WIDTH  chosen CU
- alloc_slot_id_o  out  `WG_SLOT_ID_WIDTH  chosen WG slot
- dealloc_valid_i  in  1  WG completion valid
- dealloc_ready_o  out  1  completion accepted this cycle
- dealloc_cu_id_i  in  CU_ID_WIDTH  completing CU
- dealloc_slot_id_i  in  `WG_SLOT_ID_WIDTH  completing slot
- tbl_cu_id_o  out  CU_ID_WIDTH  table CU select
- tbl_alloc_en_o  out  1  table alloc strobe
- tbl_dealloc_en_o  out  1  table dealloc strobe
- tbl_wf_count_o  out  `WF_COUNT_WIDTH_PER_WG  table alloc amount
- tbl_alloc_wg_slot_id_o  out  `WG_SLOT_ID_WIDTH  table alloc slot
- tbl_dealloc_wg_slot_id_o  out  `WG_SLOT_ID_WIDTH  table dealloc slot
- tbl_wf_count_i  in  `WF_COUNT_WIDTH  free wavefronts of the CU selected on the previous cycle
- dealloc_err_o  out  1  sticky: dealloc targeted an idle slot

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE.
  - Slot-busy bitmap (NUMBER_CU x 2^`WG_SLOT_ID_WIDTH) is cleared.
  - Registered request count is cleared.
- Table read latency is 1 cycle: the value of tbl_wf_count_i at cycle k+1 corresponds to tbl_cu_id_o at cycle k.
- tbl_alloc_en_o and tbl_dealloc_en_o are never asserted together (SVA).
- State IDLE:
  - If dealloc_valid_i: assert dealloc_ready_o. Dealloc has priority over a new WG.
    - If the slot is busy: same cycle, tbl_cu_id_o=dealloc_cu_id_i, tbl_dealloc_en_o=1, tbl_dealloc_wg_slot_id_o=dealloc_slot_id_i; clear the busy bit on the next edge.
    - If the slot is idle: no strobe; set dealloc_err_o.
  - Else if wg_valid_i: assert wg_ready_o, register wg_wf_count_i, go to SCAN with scan_ptr=start CU.
- State SCAN:
  - Each cycle drive tbl_cu_id_o=scan_ptr and evaluate the CU presented last cycle.
  - A CU fits when tbl_wf_count_i >= registered count (unsigned, zero-extended) and it has at least one idle slot. The slot chosen is the lowest-index idle slot.
  - On the first fit: go to ALLOC.
  - When all NUMBER_CU CUs have been evaluated with no fit: go to WAIT.
  - scan_ptr wraps modulo NUMBER_CU.
  - Worst-case scan is NUMBER_CU+1 cycles.
- State ALLOC (1 cycle):
  - tbl_cu_id_o=chosen CU, tbl_alloc_en_o=1, tbl_wf_count_o=registered count, tbl_alloc_wg_slot_id_o=chosen slot.
  - Set the busy bit. Go to RESP.
- State RESP:
  - alloc_valid_o=1 with alloc_cu_id_o and alloc_slot_id_o held stable until alloc_ready_i.
  - Then go to IDLE.
  - Deallocs are stalled (dealloc_ready_o=0) in SCAN, ALLOC and RESP.
- State WAIT:
  - Accepts deallocs exactly as in IDLE. After any dealloc that issues a table strobe, go to SCAN (rescan from start CU).
  - Erroneous deallocs do not trigger a rescan.
  - wg_ready_o=0.
- Zero wg_wf_count_i is illegal (SVA); a count > `WF_COUNT_MAX waits forever (not checked).
- Async reset mid-operation abandons the pending WG with no result. The table is reset by the same rst_n, so the two stay consistent.

Optional Feature:
- WG_ALLOC_RR_EN defined: the start CU is (last allocated CU + 1) mod NUMBER_CU, held in a register that resets to 0.
- Undefined: the start CU is always 0 (first-fit, lowest CU index).

Decomposition:
- Shared package/define.v: `WF_COUNT_WIDTH, `WF_COUNT_WIDTH_PER_WG, `WG_SLOT_ID_WIDTH, `WF_COUNT_MAX, FSM state encodings (IDLE/SCAN/ALLOC/RESP/WAIT).
- One sub-module: wg_slot_pick_first, a combinational lowest-idle-slot finder returning slot id and a found flag for one CU's bitmap row.

Test Plan:
- Bench build: NUMBER_CU=2, `WF_COUNT_MAX=8, 4 slots per CU.
- Basic alloc: WG count 3 from reset → one tbl_alloc_en with cu 0 / slot 0 / count 3; alloc_valid_o with cu0/slot0; table free for CU0 = 5.
- Spill to CU1: allocate 6 then 4 → second WG lands on cu1 / slot0; scan time ≤ 3 cycles.
- Wait and rescan: fill both CUs to 8, request 2 → WAIT, wg_ready low. Dealloc cu1/slot0 (count 8) → rescan, alloc cu1/slot0.
- Slot exhaustion: four WGs of count 1 on CU0 fill all 4 slots → fifth WG goes to cu1 even though CU0 has 4 free WFs.
- Bad dealloc: dealloc of an idle cu0/slot3 → no tbl_dealloc_en, dealloc_err_o sticky 1; simultaneous wg_valid in IDLE waits one cycle for the dealloc to complete first.
- WG_ALLOC_RR_EN: two WGs of count 1 → cu0 then cu1; without the macro → cu0 twice.
